// File: rtl/edge_sched_pkg.sv
// rtl/edge_sched_pkg.sv - shared FSM states and round-robin helpers for edge_event_scheduler
package edge_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Upper bound on arbitration sources (16 channels, two banks each).
   localparam int MAX_SRC = 32;

   // First set request found by scanning ptr, ptr+1, ... wrapping at n.
   function automatic logic [4:0] rr_pick(input logic [31:0] req,
                                          input logic [4:0]  ptr,
                                          input logic [5:0]  n);
      logic [5:0] idx;
      logic [4:0] pick;
      logic       found;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_SRC; k++) begin
         idx = {1'b0, ptr} + 6'(k);
         if (idx >= n) begin
            idx = idx - n;
         end
         if (!found && (6'(k) < n) && req[idx[4:0]]) begin
            pick  = idx[4:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Index following idx, wrapping to 0 at n.
   function automatic logic [4:0] rr_next(input logic [4:0] idx,
                                          input logic [5:0] n);
      logic [5:0] nxt;
      nxt = {1'b0, idx} + 6'd1;
      if (nxt >= n) begin
         nxt = 6'd0;
      end
      return 5'(nxt);
   endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - per-channel edge detect with pending/overflow latch (FALL_EDGE_EN adds a falling bank)
module edge_chan (
   input  logic clk,
   input  logic reset,
   input  logic level,
   input  logic take,
`ifdef FALL_EDGE_EN
   input  logic take_fall,
   output logic pending_fall,
`endif
   input  logic ovf_clear,
   output logic pending,
   output logic overflow
);

   logic r_lvl_q;
   logic r_pend;
   logic r_ovf;
   logic w_rise;
   logic w_ovf_set;

   assign w_rise    = level & ~r_lvl_q;
   // A rise that is consumed by the same-cycle take re-arms pending without counting as overflow.
   assign w_ovf_set = w_rise & r_pend & ~take;

   // Previous-level register used for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lvl_q <= 1'b0;
      end else begin
         r_lvl_q <= level;
      end
   end

   // Rising-edge pending flag and sticky overflow; a new overflow beats ovf_clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (take & w_rise) begin
            r_pend <= 1'b1;
         end else if (take) begin
            r_pend <= 1'b0;
         end else if (w_rise) begin
            r_pend <= 1'b1;
         end
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (ovf_clear) begin
            r_ovf <= 1'b0;
         end
      end
   end

`ifdef FALL_EDGE_EN
   logic r_pend_f;
   logic r_ovf_f;
   logic w_fall;
   logic w_ovf_set_f;

   assign w_fall      = ~level & r_lvl_q;
   assign w_ovf_set_f = w_fall & r_pend_f & ~take_fall;

   // Falling-edge bank, same priority rules as the rising bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_f <= 1'b0;
         r_ovf_f  <= 1'b0;
      end else begin
         if (take_fall & w_fall) begin
            r_pend_f <= 1'b1;
         end else if (take_fall) begin
            r_pend_f <= 1'b0;
         end else if (w_fall) begin
            r_pend_f <= 1'b1;
         end
         if (w_ovf_set_f) begin
            r_ovf_f <= 1'b1;
         end else if (ovf_clear) begin
            r_ovf_f <= 1'b0;
         end
      end
   end

   assign pending_fall = r_pend_f;
   assign overflow     = r_ovf | r_ovf_f;
`else
   assign overflow     = r_ovf;
`endif

   assign pending = r_pend;

endmodule

// File: rtl/edge_event_scheduler.sv
// rtl/edge_event_scheduler.sv - round-robin hand-off of latched level edges to one consumer (FALL_EDGE_EN adds falling edges)
module edge_event_scheduler #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   level,
   output logic           event_valid,
   input  logic           event_ready,
   output logic [IDW-1:0] event_id,
`ifdef FALL_EDGE_EN
   output logic           event_fall,
`endif
   output logic [N-1:0]   pending,
   output logic [N-1:0]   overflow,
   input  logic           ovf_clear
);

   import edge_sched_pkg::*;

`ifdef FALL_EDGE_EN
   localparam logic [5:0] SRC_N = 6'(2 * N);
`else
   localparam logic [5:0] SRC_N = 6'(N);
`endif

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_load;
   logic           w_hs;
   logic [IDW-1:0] r_event_id;
   logic [IDW-1:0] r_rr_ptr;
   logic [N-1:0]   w_pend_r;
   logic [N-1:0]   w_ovf;
   logic [N-1:0]   w_take;
   logic [31:0]    w_req;
   logic [4:0]     w_ptr;
   logic [4:0]     w_pick;
   logic [IDW-1:0] w_pick_id;
   logic           w_any;

   assign w_hs = (r_state == GRANT) & event_ready;

`ifdef FALL_EDGE_EN
   logic [N-1:0] w_pend_f;
   logic [N-1:0] w_take_f;
   logic         r_event_fall;
   logic         w_pick_fall;

   // Interleave banks so each channel's rise is scanned just before its fall.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < N; i++) begin
         w_req[2*i]   = w_pend_r[i];
         w_req[2*i+1] = w_pend_f[i];
      end
   end

   assign w_ptr       = 5'({r_rr_ptr, 1'b0});
   assign w_pick      = rr_pick(w_req, w_ptr, SRC_N);
   assign w_pick_id   = IDW'(w_pick >> 1);
   assign w_pick_fall = w_pick[0];
   assign event_fall  = r_event_fall;
`else
   // Only the rising bank participates in arbitration.
   always_comb begin
      w_req        = '0;
      w_req[N-1:0] = w_pend_r;
   end

   assign w_ptr     = 5'(r_rr_ptr);
   assign w_pick    = rr_pick(w_req, w_ptr, SRC_N);
   assign w_pick_id = IDW'(w_pick);
`endif

   assign w_any = |w_req;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
`ifdef FALL_EDGE_EN
         assign w_take[gi]   = w_hs & (r_event_id == IDW'(gi)) & ~r_event_fall;
         assign w_take_f[gi] = w_hs & (r_event_id == IDW'(gi)) &  r_event_fall;
`else
         assign w_take[gi]   = w_hs & (r_event_id == IDW'(gi));
`endif
         edge_chan u_chan (
            .clk          (clk),
            .reset        (reset),
            .level        (level[gi]),
            .take         (w_take[gi]),
`ifdef FALL_EDGE_EN
            .take_fall    (w_take_f[gi]),
            .pending_fall (w_pend_f[gi]),
`endif
            .ovf_clear    (ovf_clear),
            .pending      (w_pend_r[gi]),
            .overflow     (w_ovf[gi])
         );
      end
   endgenerate

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and valid: offer from IDLE when anything is pending, hold in GRANT until accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      event_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_load      = 1'b1;
            end
         end
         GRANT: begin
            event_valid = 1'b1;
            if (event_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Offered id is captured on the IDLE decision; the pointer advances past it on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_event_id   <= '0;
         r_rr_ptr     <= '0;
`ifdef FALL_EDGE_EN
         r_event_fall <= 1'b0;
`endif
      end else begin
         if (w_load) begin
            r_event_id   <= w_pick_id;
`ifdef FALL_EDGE_EN
            r_event_fall <= w_pick_fall;
`endif
         end
         if (w_hs) begin
            r_rr_ptr <= IDW'(rr_next(5'(r_event_id), 6'(N)));
         end
      end
   end

   assign event_id = r_event_id;
   assign pending  = w_pend_r;
   assign overflow = w_ovf;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// tb/tb_edge_event_scheduler.sv - self-checking bench for edge_event_scheduler (FALL_EDGE_EN selects the falling-edge test)
module tb_edge_event_scheduler;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   level = '0;
   logic           event_ready = 1'b0;
   logic           ovf_clear = 1'b0;
   logic           event_valid;
   logic [IDW-1:0] event_id;
   logic [N-1:0]   pending;
   logic [N-1:0]   overflow;
`ifdef FALL_EDGE_EN
   logic           event_fall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   edge_event_scheduler #(.N(N), .IDW(IDW)) dut (
      .clk         (clk),
      .reset       (reset),
      .level       (level),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .event_id    (event_id),
`ifdef FALL_EDGE_EN
      .event_fall  (event_fall),
`endif
      .pending     (pending),
      .overflow    (overflow),
      .ovf_clear   (ovf_clear)
   );

   always #5 clk = ~clk;

   // Reference model state: offered event, per-channel flags, pointer.
   logic [N-1:0] m_prev = '0;
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_ovf  = '0;
   bit           m_offer = 1'b0;
   int           m_id  = 0;
   int           m_ptr = 0;

   typedef struct {
      logic [3:0] lv;
      logic       rdy;
      logic       clr;
      logic       rst;
      logic       ev;
      logic [1:0] id;
      logic [3:0] pend;
      logic [3:0] ovf;
   } vec_t;

   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic [N-1:0] lv, input bit rdy, input bit clr, input bit rst);
      logic [N-1:0] np;
      logic [N-1:0] no;
      bit hs;
      bit rise;
      bit taken;
      bit newovf;
      if (rst) begin
         m_prev = '0; m_pend = '0; m_ovf = '0;
         m_offer = 1'b0; m_id = 0; m_ptr = 0;
         return;
      end
      hs = m_offer && rdy;
      for (int i = 0; i < N; i++) begin
         rise   = lv[i] && !m_prev[i];
         taken  = hs && (m_id == i);
         newovf = !taken && rise && m_pend[i];
         np[i]  = taken ? rise : (rise ? 1'b1 : m_pend[i]);
         no[i]  = newovf ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
      end
      if (m_offer) begin
         if (hs) begin
            m_offer = 1'b0;
            m_ptr   = (m_id + 1) % N;
         end
      end else if (m_pend != 0) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (m_pend[(m_ptr + k) % N]) m_id = (m_ptr + k) % N;
         end
         m_offer = 1'b1;
      end
      m_pend = np;
      m_ovf  = no;
      m_prev = lv;
   endtask

   task automatic cycle(input logic [N-1:0] lv, input bit rdy, input bit clr, input bit rst);
      level = lv; event_ready = rdy; ovf_clear = clr; reset = rst;
      model_step(lv, rdy, clr, rst);
      @(posedge clk);
      #1;
`ifndef FALL_EDGE_EN
      check("model_valid", 32'(event_valid), 32'(m_offer));
      if (m_offer) check("model_id", 32'(event_id), 32'(m_id));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifndef FALL_EDGE_EN
      int cnt;
      logic [N-1:0] lv;
      bit rdy_mode;
`else
      int nev;
      logic [1:0] ids[2];
      logic falls[2];
`endif

`ifndef FALL_EDGE_EN
      // Single held level, then double pulse with overflow and clear.
      tv.push_back('{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0});
      tv.push_back('{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 4'h0});
      tv.push_back('{4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 4'h0});
      for (int r = 0; r < 8; r++)
         tv.push_back('{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0});
      tv.push_back('{4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
      tv.push_back('{4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h4});
      tv.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0});
      tv.push_back('{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0});
      tv.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0});

      foreach (tv[r]) begin
         cycle(tv[r].lv, tv[r].rdy, tv[r].clr, tv[r].rst);
         check($sformatf("vec%0d_valid", r), 32'(event_valid), 32'(tv[r].ev));
         if (tv[r].ev || tv[r].rst)
            check($sformatf("vec%0d_id", r), 32'(event_id), 32'(tv[r].id));
         check($sformatf("vec%0d_pending", r), 32'(pending), 32'(tv[r].pend));
         check($sformatf("vec%0d_overflow", r), 32'(overflow), 32'(tv[r].ovf));
      end

      // All four channels rise together: served 0..3, one bubble between grants.
      cycle(4'h0, 1'b1, 1'b0, 1'b1);
      cycle(4'hF, 1'b1, 1'b0, 1'b0);
      check("t2_pending", 32'(pending), 32'hF);
      for (int j = 0; j < 4; j++) begin
         cnt = 0;
         while (!event_valid && cnt < 8) begin
            cycle(4'hF, 1'b1, 1'b0, 1'b0);
            cnt++;
         end
         check($sformatf("t2_gap%0d", j), 32'(cnt), 32'd1);
         check($sformatf("t2_id%0d", j), 32'(event_id), 32'(j));
         cycle(4'hF, 1'b1, 1'b0, 1'b0);
         check($sformatf("t2_bubble%0d", j), 32'(event_valid), 32'd0);
      end
      cycle(4'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'h9, 1'b0, 1'b0, 1'b0);
      cycle(4'h9, 1'b0, 1'b0, 1'b0);
      check("t2_ptr_wrap_id", 32'(event_id), 32'd0);
      for (int j = 0; j < 4; j++) cycle(4'h0, 1'b1, 1'b0, 1'b0);
      check("t2_drained", 32'(pending), 32'h0);

      // Take and new rise on the same channel in the same cycle.
      cycle(4'h0, 1'b0, 1'b0, 1'b1);
      cycle(4'h2, 1'b0, 1'b0, 1'b0);
      cycle(4'h2, 1'b0, 1'b0, 1'b0);
      check("t4_offer_id", 32'(event_id), 32'd1);
      cycle(4'h0, 1'b0, 1'b0, 1'b0);
      cycle(4'h2, 1'b1, 1'b0, 1'b0);
      check("t4_hs_valid", 32'(event_valid), 32'd0);
      check("t4_pending", 32'(pending), 32'h2);
      check("t4_overflow", 32'(overflow), 32'h0);
      cycle(4'h2, 1'b1, 1'b0, 1'b0);
      check("t4_reoffer_valid", 32'(event_valid), 32'd1);
      check("t4_reoffer_id", 32'(event_id), 32'd1);
      cycle(4'h2, 1'b1, 1'b0, 1'b0);
      check("t4_done", 32'(pending), 32'h0);

      // Reset mid-handshake with three channels pending and an overflow.
      cycle(4'h0, 1'b0, 1'b0, 1'b1);
      cycle(4'h7, 1'b0, 1'b0, 1'b0);
      check("t5_pending", 32'(pending), 32'h7);
      cycle(4'h6, 1'b0, 1'b0, 1'b0);
      check("t5_valid", 32'(event_valid), 32'd1);
      cycle(4'h7, 1'b0, 1'b0, 1'b0);
      check("t5_overflow", 32'(overflow), 32'h1);
      cycle(4'h7, 1'b0, 1'b0, 1'b1);
      check("t5_rst_valid", 32'(event_valid), 32'd0);
      check("t5_rst_pending", 32'(pending), 32'h0);
      check("t5_rst_overflow", 32'(overflow), 32'h0);
      check("t5_rst_id", 32'(event_id), 32'd0);

      // Randomized traffic against the reference model.
      lv = '0;
      rdy_mode = 1'b0;
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
         if ($urandom_range(0, 63) == 0) rdy_mode = ~rdy_mode;
         cycle(lv, rdy_mode ? 1'b1 : 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end
`else
      // Falling-edge bank: a 4-cycle pulse yields a rise then a fall event.
      cycle(4'h0, 1'b1, 1'b0, 1'b1);
      check("rst_valid", 32'(event_valid), 32'd0);
      check("rst_pending", 32'(pending), 32'h0);
      nev = 0;
      ids[0] = '0; ids[1] = '0; falls[0] = 1'b0; falls[1] = 1'b0;
      for (int c = 0; c < 14; c++) begin
         cycle((c < 4) ? 4'h8 : 4'h0, 1'b1, 1'b0, 1'b0);
         if (event_valid) begin
            if (nev < 2) begin
               ids[nev]   = event_id;
               falls[nev] = event_fall;
            end
            nev++;
         end
      end
      check("t6_count", 32'(nev), 32'd2);
      check("t6_id0", 32'(ids[0]), 32'd3);
      check("t6_fall0", 32'(falls[0]), 32'd0);
      check("t6_id1", 32'(ids[1]), 32'd3);
      check("t6_fall1", 32'(falls[1]), 32'd1);
      check("t6_pending", 32'(pending), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
